// File: rtl/cim_accum.sv
// cim_accum: per-lane accumulator for quantized input beats, drained as packed wide beats.
// Three-state FSM (IDLE/ACCUM/DRAIN); all outputs come from registered state.
module cim_accum #(
    parameter int LANES     = 16,
    parameter int IN_W      = 4,
    parameter int ACC_W     = 8,
    parameter int OUT_LANES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [4:0]                   pass_num,
    input  logic                         in_valid,
    input  logic [LANES*IN_W-1:0]        in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [OUT_LANES*ACC_W-1:0]   out_data,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done
);
    localparam int DRAINS = LANES / OUT_LANES;
    localparam int DW = DRAINS > 1 ? $clog2(DRAINS) : 1;
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
    localparam logic [4:0] MAX_PASS = 5'd16;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]       state;
    logic [ACC_W-1:0] acc [LANES];
    logic [4:0]       pass_cnt;
    logic [4:0]       eff;
    logic [DW-1:0]    d;
    logic             take;
    logic             last_beat;
    logic             last_drain;

    assign in_ready   = state == ACCUM;
    assign out_valid  = state == DRAIN;
    assign busy       = state != IDLE;
    assign out_last   = out_valid && d == DW'(DRAINS - 1);
    assign take       = in_valid && in_ready;
    assign last_beat  = take && pass_cnt + 5'd1 == eff;
    assign last_drain = out_ready && out_last;

    // Outside DRAIN the bus reads zero; accumulators stay frozen behind the mux.
    always_comb begin
        out_data = '0;
        for (int j = 0; j < OUT_LANES; j++)
            out_data[j*ACC_W +: ACC_W] = out_valid ? acc[LW'(int'(d) * OUT_LANES + j)] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pass_cnt <= '0;
            eff      <= '0;
            d        <= '0;
            done     <= 1'b0;
            for (int i = 0; i < LANES; i++)
                acc[i] <= '0;
        end else begin
            done <= last_drain;
            if (state == IDLE && start) begin
                state    <= ACCUM;
                pass_cnt <= '0;
                eff      <= pass_num == 5'd0 ? 5'd1 : pass_num > MAX_PASS ? MAX_PASS : pass_num;
                for (int i = 0; i < LANES; i++)
                    acc[i] <= '0;
            end else if (take) begin
                pass_cnt <= pass_cnt + 5'd1;
                for (int i = 0; i < LANES; i++)
                    acc[i] <= acc[i] + ACC_W'(in_data[i*IN_W +: IN_W]);
                if (last_beat) begin
                    state <= DRAIN;
                    d     <= '0;
                end
            end else if (out_valid && out_ready) begin
                d <= out_last ? '0 : d + 1'b1;
                if (out_last)
                    state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_cim_accum.sv
// tb_cim_accum: directed and randomized jobs checked against a plain-arithmetic lane-sum model.
module tb_cim_accum;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  pass_num;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;

    int total;
    int passed;

    cim_accum dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pass_num(pass_num),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // mode: 0 all lanes F, 1 lane k = k, 2 random. Entered and left on a negedge.
    task automatic run_job(input int pn, input int mode, input bit tog, input bit stall, input bit rst_mid);
        int n;
        int got;
        int ref_sum [16];
        logic [63:0] beat;
        logic [31:0] e;
        n = pn == 0 ? 1 : (pn > 16 ? 16 : pn);
        for (int k = 0; k < 16; k++) ref_sum[k] = 0;
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
        start = 1'b1;
        pass_num = pn[4:0];
        @(negedge clk);
        start = 1'b0;
        chk("done_single_cycle", done, 0);
        chk("accum_busy", busy, 1);
        got = 0;
        for (int c = 0; c < 100; c++) begin
            beat = mode == 0 ? {16{4'hF}} : mode == 1 ? 64'hFEDCBA9876543210 : {$urandom, $urandom};
            in_valid = !(tog && c[0]);
            in_data = beat;
            if (!in_ready) break;
            if (in_valid) begin
                got++;
                for (int k = 0; k < 16; k++) ref_sum[k] += int'(beat[4*k +: 4]);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("beats_accepted", got, n);
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 4; j++) e[8*j +: 8] = 8'(ref_sum[4*b+j]);
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, e);
            chk("out_last", out_last, b == 3);
            chk("drain_in_ready", in_ready, 0);
            if (rst_mid && b == 1) begin
                rst_n = 1'b0;
                #1;
                chk_zero("async_reset");
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("post_reset_done", done, 0);
                    chk("post_reset_busy", busy, 0);
                end
                return;
            end
            if (stall && b == 2) begin
                out_ready = 1'b0;
                start = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    start = 1'b0;
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, e);
                    chk("stall_last", out_last, 0);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("done_pulse", done, 1);
        chk("idle_after_drain", busy, 0);
        chk("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst_n = 1'b0;
        start = 1'b0;
        pass_num = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        #1;
        chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(1, 0, 0, 0, 0);
        run_job(16, 0, 0, 0, 0);
        run_job(3, 1, 1, 0, 0);
        run_job(0, 2, 0, 0, 0);
        @(negedge clk);
        run_job(20, 2, 1, 0, 0);
        run_job(5, 2, 0, 1, 0);
        run_job(2, 2, 0, 0, 1);
        run_job(7, 2, 0, 0, 0);
        for (int r = 0; r < 6; r++) begin
            run_job(int'($urandom_range(0, 20)), 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            if (r[0]) @(negedge clk);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cim_accum.md
CIM_ACCUM -- requirements
Module: cim_accum

Interface
REQ-001 Parameter LANES, default 16, number of 4-bit quantized lanes per input beat.
REQ-002 Parameter IN_W, default 4, width of each input lane (unsigned).
REQ-003 Parameter ACC_W, default 8, width of each lane accumulator (unsigned).
REQ-004 Parameter OUT_LANES, default 4, accumulator lanes packed per output beat.
REQ-005 Clocking: one clock. Reset is asynchronous and active-low. Port names are clk and rst_n.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  single-cycle pulse that begins a job; honoured only in IDLE.
REQ-009 pass_num  input  5  number of input beats to accumulate; sampled on an accepted start.
REQ-010 in_valid  input  1  upstream quantizer beat is valid.
REQ-011 in_data  input  64  16 lanes x 4 bits; lane k at bits [4k+3:4k].
REQ-012 in_ready  output  1  block accepts an input beat this cycle.
REQ-013 out_valid  output  1  out_data holds a valid drain beat.
REQ-014 out_data  output  32  4 lanes x 8 bits; lowest lane index in the LSBs.
REQ-015 out_last  output  1  asserted with the final drain beat.
REQ-016 out_ready  input  1  downstream accepts the current beat.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse when a job completes.

Function
REQ-019 The FSM SHALL have exactly three states, IDLE, ACCUM and DRAIN, and all outputs SHALL be registered or decoded from registered state only.
REQ-020 IDLE->ACCUM on start=1; on the same edge, all 16 accumulators SHALL clear to 0, pass_cnt SHALL clear to 0, and the effective pass count SHALL latch as 1 if pass_num=0, 16 if pass_num>16, otherwise pass_num.
REQ-021 start SHALL be ignored in ACCUM and DRAIN.
REQ-022 in_ready SHALL equal 1 exactly when state=ACCUM.
REQ-023 On each accepted beat (in_valid & in_ready), acc[k] SHALL become acc[k] + zero-extended lane k, and pass_cnt SHALL increment.
REQ-024 When the accepted beat is beat number N (effective count), the state SHALL go ACCUM->DRAIN on that edge. The sum SHALL include that beat, and no further input SHALL be accepted.
REQ-025 With 4-bit unsigned lanes, the maximum sum is 16 x 15 = 240. The accumulator SHALL NOT wrap or saturate, and no overflow logic is required.
REQ-026 In DRAIN, out_valid SHALL be 1 and drain index d (0..3) SHALL select lanes 4d..4d+3, with lane 4d at out_data[7:0].
REQ-027 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 On out_valid & out_ready, d SHALL increment. out_last SHALL be 1 only when d=3.
REQ-029 When the beat with d=3 is accepted, the state SHALL go DRAIN->IDLE, and done SHALL pulse 1 in the following cycle.
REQ-030 A start asserted in the same cycle as done SHALL be honoured, because the state is already IDLE.
REQ-031 Minimum job latency SHALL be: start edge, then N beats at one per cycle, then 4 drain cycles when out_ready is held 1, then done.
REQ-032 Accumulators SHALL be frozen in IDLE and DRAIN, and the values from the last job SHALL remain until the next start.

Reset
REQ-033 When rst_n=0, the block SHALL asynchronously force: state=IDLE, acc=0, pass_cnt=0, d=0, in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0.
REQ-034 Reset asserted mid-ACCUM or mid-DRAIN SHALL abandon the job with no done pulse. After release, the block SHALL wait for a new start.
REQ-035 Reset release SHALL be synchronous to clk externally. The first start is legal on the first edge after release.

Verification
REQ-036 pass_num=1, a single beat with all lanes=4'hF, out_ready=1 -> 4 drain beats, each out_data=32'h0F0F0F0F, out_last on beat 4, done 1 cycle later.
REQ-037 pass_num=16, 16 beats with all lanes=4'hF -> every lane 8'hF0 (240), no wrap.
REQ-038 pass_num=3, beats with lane k = k mod 16, in_valid toggled 1/0 -> lane k = 3k; beat0 = 32'h09060300, beat3 = 32'h2D2A2724.
REQ-039 pass_num=0 -> exactly one beat accepted. pass_num=20 -> exactly 16 accepted, then in_ready=0.
REQ-040 out_ready held 0 for 5 cycles in DRAIN -> out_data and out_last stable, d unchanged. start pulsed during DRAIN -> ignored.
REQ-041 rst_n pulsed low mid-DRAIN -> all outputs 0 immediately, no done pulse. A new job afterwards produces correct sums from cleared accumulators.
